// File: rtl/tx_sched_pkg.sv
// ----------------------------------------------------------------------------
// tx_sched_pkg
// Shared types and defaults for the transmit credit scheduler.
//   fc_type_e : PCIe flow-control class carried with each request / update.
//   state_e   : grant FSM states.
// ----------------------------------------------------------------------------
package tx_sched_pkg;

    typedef enum logic [1:0] {
        FC_P    = 2'd0,
        FC_NP   = 2'd1,
        FC_CPL  = 2'd2,
        FC_RSVD = 2'd3
    } fc_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_BUSY
    } state_e;

    // Number of real credit classes (FC_RSVD has no counters).
    localparam int NUM_FC     = 3;
    localparam int HDR_W_DEF  = 8;
    localparam int DATA_W_DEF = 12;

endpackage

// File: rtl/rr_select.sv
// ----------------------------------------------------------------------------
// rr_select
// Rotating-priority encoder: returns the first set bit of `elig` found when
// scanning upward from `ptr`, wrapping at N. Purely combinational.
//   elig  : candidate vector
//   ptr   : index with highest priority this cycle
//   sel   : chosen index (0 when nothing is eligible)
//   found : at least one candidate was eligible
// ----------------------------------------------------------------------------
module rr_select #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] sel,
    output logic          found
);

    int idx;

    // NOTE: every signal driven here gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/tx_credit_scheduler.sv
// ----------------------------------------------------------------------------
// tx_credit_scheduler
// Arbitrates the single TLP-buffer write path between NUM_REQ sources while
// tracking header/data flow-control credits per class (P, NP, CPL).
//   clk, arst          : clock, synchronous active-high reset
//   req/req_type/req_data_cred : per-source pending flag, FC class, data need
//   gnt, gnt_idx, busy : one-hot grant pulse, last granted index, path owned
//   xfer_done          : granted TLP fully written, path released
//   fc_upd_*           : DLL credit return for one class
//   fc_overflow        : pulse when a return saturated a counter
// ----------------------------------------------------------------------------
module tx_credit_scheduler
    import tx_sched_pkg::*;
#(
    parameter int                NUM_REQ   = 4,
    parameter int                HDR_W     = HDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [HDR_W-1:0]  INIT_HDR  = HDR_W'(32),
    parameter logic [DATA_W-1:0] INIT_DATA = DATA_W'(256)
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [2*NUM_REQ-1:0]        req_type,
    input  logic [DATA_W*NUM_REQ-1:0]   req_data_cred,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [$clog2(NUM_REQ)-1:0]  gnt_idx,
    output logic                        busy,
    input  logic                        xfer_done,
    input  logic                        fc_upd_valid,
    input  logic [1:0]                  fc_upd_type,
    input  logic [HDR_W-1:0]            fc_upd_hdr,
    input  logic [DATA_W-1:0]           fc_upd_data,
    output logic                        fc_overflow
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   sel;
    logic               found;

    logic [HDR_W-1:0]   hdr_avail  [NUM_FC];
    logic [DATA_W-1:0]  data_avail [NUM_FC];
    logic [HDR_W-1:0]   hdr_next   [NUM_FC];
    logic [DATA_W-1:0]  data_next  [NUM_FC];
    logic               sat_any;

    logic [NUM_REQ-1:0] fits;
    logic [NUM_REQ-1:0] is_p;
    logic [NUM_REQ-1:0] elig;
    logic               p_blocked;
    logic [1:0]         sel_type;
    logic [DATA_W-1:0]  sel_cred;

    // Credit check per requester; reserved type never matches a class.
    always_comb begin
        fits = '0;
        is_p = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            is_p[i] = (req_type[2*i +: 2] == FC_P);
            for (int t = 0; t < NUM_FC; t++) begin
                if (req_type[2*i +: 2] == 2'(t)) begin
                    fits[i] = (hdr_avail[t] != '0) &&
                              (data_avail[t] >= req_data_cred[DATA_W*i +: DATA_W]);
                end
            end
        end
    end

    // A starved posted TLP must not be overtaken by NP/CPL traffic.
    assign p_blocked = |(req & is_p & ~fits);

    always_comb begin
        elig = req & fits & (is_p | {NUM_REQ{~p_blocked}});
        if (state != S_IDLE) elig = '0;
    end

    rr_select #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr_select (
        .elig  (elig),
        .ptr   (rr_ptr),
        .sel   (sel),
        .found (found)
    );

    always_comb begin
        sel_type = '0;
        sel_cred = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == IDX_W'(i)) begin
                sel_type = req_type[2*i +: 2];
                sel_cred = req_data_cred[DATA_W*i +: DATA_W];
            end
        end
    end

    // Return and consumption on the same class combine at W+1 bits; the
    // extra bit flags saturation. Consumption cannot underflow because the
    // granted requester passed the credit check against the same counters.
    logic [HDR_W:0]  hdr_sum;
    logic [DATA_W:0] data_sum;
    logic            upd_hit;
    logic            use_hit;

    always_comb begin
        sat_any  = 1'b0;
        hdr_sum  = '0;
        data_sum = '0;
        upd_hit  = 1'b0;
        use_hit  = 1'b0;
        for (int t = 0; t < NUM_FC; t++) begin
            upd_hit  = fc_upd_valid && (fc_upd_type == 2'(t));
            use_hit  = found && (sel_type == 2'(t));
            hdr_sum  = {1'b0, hdr_avail[t]}
                     + (upd_hit ? {1'b0, fc_upd_hdr} : '0)
                     - (use_hit ? (HDR_W+1)'(1) : '0);
            data_sum = {1'b0, data_avail[t]}
                     + (upd_hit ? {1'b0, fc_upd_data} : '0)
                     - (use_hit ? {1'b0, sel_cred} : '0);
            hdr_next[t]  = hdr_sum[HDR_W]   ? '1 : hdr_sum[HDR_W-1:0];
            data_next[t] = data_sum[DATA_W] ? '1 : data_sum[DATA_W-1:0];
            sat_any = sat_any | hdr_sum[HDR_W] | data_sum[DATA_W];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values and simulation order cannot matter.
    always_ff @(posedge clk) begin
        if (arst) begin
            state       <= S_IDLE;
            gnt         <= '0;
            gnt_idx     <= '0;
            busy        <= 1'b0;
            fc_overflow <= 1'b0;
            rr_ptr      <= '0;
            // NOTE: the credit arrays are architectural state and must come
            // out of reset at their initial allotment, so they are reset
            // explicitly (unlike a data-path memory would be).
            for (int t = 0; t < NUM_FC; t++) begin
                hdr_avail[t]  <= INIT_HDR;
                data_avail[t] <= INIT_DATA;
            end
        end else begin
            for (int t = 0; t < NUM_FC; t++) begin
                hdr_avail[t]  <= hdr_next[t];
                data_avail[t] <= data_next[t];
            end
            fc_overflow <= sat_any;

            case (state)
                S_IDLE: begin
                    gnt <= '0;
                    if (found) begin
                        state   <= S_GRANT;
                        gnt     <= NUM_REQ'(1) << sel;
                        gnt_idx <= sel;
                        busy    <= 1'b1;
                        rr_ptr  <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                    end
                end
                S_GRANT: begin
                    gnt <= '0;
                    if (xfer_done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (xfer_done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_credit_scheduler.sv
// ----------------------------------------------------------------------------
// tb_tx_credit_scheduler
// Directed scenarios for tx_credit_scheduler. Expected grants are queued by
// the stimulus; an independent monitor pops and compares on every grant.
// ----------------------------------------------------------------------------
module tb_tx_credit_scheduler;
    import tx_sched_pkg::*;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [3:0]  req = '0;
    logic [7:0]  req_type = '0;
    logic [47:0] req_data_cred = '0;
    logic [3:0]  gnt;
    logic [1:0]  gnt_idx;
    logic        busy;
    logic        xfer_done = 1'b0;
    logic        fc_upd_valid = 1'b0;
    logic [1:0]  fc_upd_type = '0;
    logic [7:0]  fc_upd_hdr = '0;
    logic [11:0] fc_upd_data = '0;
    logic        fc_overflow;

    tx_credit_scheduler dut (
        .clk           (clk),
        .arst          (arst),
        .req           (req),
        .req_type      (req_type),
        .req_data_cred (req_data_cred),
        .gnt           (gnt),
        .gnt_idx       (gnt_idx),
        .busy          (busy),
        .xfer_done     (xfer_done),
        .fc_upd_valid  (fc_upd_valid),
        .fc_upd_type   (fc_upd_type),
        .fc_upd_hdr    (fc_upd_hdr),
        .fc_upd_data   (fc_upd_data),
        .fc_overflow   (fc_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int mon_e;
    int g;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every grant must match the head of the queue.
    always @(negedge clk) begin
        if (gnt !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_gnt: got %b expected none", gnt);
            end else begin
                mon_e = exp_q.pop_front();
                check("gnt", 32'(gnt), 32'(1 << mon_e));
                check("gnt_idx", 32'(gnt_idx), 32'(mon_e));
            end
        end
    end

    task automatic do_reset;
        @(negedge clk);
        arst = 1'b1;
        req = '0;
        req_type = '0;
        req_data_cred = '0;
        xfer_done = 1'b0;
        fc_upd_valid = 1'b0;
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [1:0] ty, input logic [11:0] cr);
        req[i] = 1'b1;
        req_type[2*i +: 2] = ty;
        req_data_cred[12*i +: 12] = cr;
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt != 4'b0000) begin
                for (int i = 0; i < 4; i++) if (gnt[i]) idx = i;
                break;
            end
        end
        if (idx < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: got no grant expected one within 20 cycles");
        end
    endtask

    task automatic end_xfer;
        xfer_done = 1'b1;
        @(negedge clk);
        xfer_done = 1'b0;
    endtask

    task automatic serve(input bit drop);
        int idx;
        wait_grant(idx);
        if (idx >= 0 && drop) req[idx] = 1'b0;
        end_xfer();
    endtask

    task automatic fc_update(input logic [1:0] ty, input logic [7:0] h, input logic [11:0] d);
        fc_upd_valid = 1'b1;
        fc_upd_type  = ty;
        fc_upd_hdr   = h;
        fc_upd_data  = d;
        @(negedge clk);
        fc_upd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state, single posted grant, busy held until xfer_done
        do_reset();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_gnt_idx", 32'(gnt_idx), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(fc_overflow), 0);
        check("rst_hdr_p", 32'(dut.hdr_avail[0]), 32);
        check("rst_data_p", 32'(dut.data_avail[0]), 256);
        check("rst_data_cpl", 32'(dut.data_avail[2]), 256);
        exp_q.push_back(0);
        set_req(0, FC_P, 12'd4);
        wait_grant(g);
        check("s1_hdr_p", 32'(dut.hdr_avail[0]), 31);
        check("s1_data_p", 32'(dut.data_avail[0]), 252);
        check("s1_busy_grant", 32'(busy), 1);
        req[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("s1_busy_hold", 32'(busy), 1);
        end
        end_xfer();
        check("s1_busy_release", 32'(busy), 0);

        // 2: round robin over four CPL sources
        do_reset();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        for (int i = 0; i < 4; i++) set_req(i, FC_CPL, 12'd0);
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            if (k == 4) req = '0;
            end_xfer();
        end
        check("s2_hdr_cpl", 32'(dut.hdr_avail[2]), 27);
        check("s2_data_cpl", 32'(dut.data_avail[2]), 256);

        // 3: starved posted request blocks NP until credits return
        do_reset();
        exp_q.push_back(3);
        set_req(3, FC_P, 12'd254);
        serve(1'b1);
        check("s3_data_p", 32'(dut.data_avail[0]), 2);
        exp_q.push_back(0);
        exp_q.push_back(1);
        set_req(0, FC_P, 12'd4);
        set_req(1, FC_NP, 12'd0);
        repeat (5) @(negedge clk);
        check("s3_blocked_busy", 32'(busy), 0);
        fc_update(FC_P, 8'd0, 12'd2);
        serve(1'b1);
        serve(1'b1);
        check("s3_data_p_after", 32'(dut.data_avail[0]), 0);
        check("s3_hdr_np", 32'(dut.hdr_avail[1]), 31);

        // 4: NP header exhaustion lets CPL pass, NP resumes after a return
        do_reset();
        for (int k = 0; k < 32; k++) exp_q.push_back(0);
        set_req(0, FC_NP, 12'd0);
        for (int k = 0; k < 32; k++) serve(k == 31);
        check("s4_hdr_np_empty", 32'(dut.hdr_avail[1]), 0);
        exp_q.push_back(3);
        exp_q.push_back(2);
        set_req(2, FC_NP, 12'd0);
        set_req(3, FC_CPL, 12'd0);
        serve(1'b1);
        repeat (4) @(negedge clk);
        check("s4_np_held", 32'(busy), 0);
        fc_update(FC_NP, 8'd1, 12'd0);
        serve(1'b1);
        check("s4_hdr_np_after", 32'(dut.hdr_avail[1]), 0);
        check("s4_hdr_cpl", 32'(dut.hdr_avail[2]), 31);

        // 5: same-edge consume and return on the posted class
        do_reset();
        exp_q.push_back(3);
        set_req(3, FC_P, 12'd156);
        serve(1'b1);
        check("s5_data_p_pre", 32'(dut.data_avail[0]), 100);
        exp_q.push_back(0);
        set_req(0, FC_P, 12'd4);
        fc_update(FC_P, 8'd0, 12'd10);
        check("s5_gnt_same_edge", 32'(gnt), 1);
        check("s5_data_p_net", 32'(dut.data_avail[0]), 106);
        check("s5_hdr_p", 32'(dut.hdr_avail[0]), 30);
        req[0] = 1'b0;
        end_xfer();

        // 6: header saturation, then reset in the middle of a transfer
        fc_update(FC_P, 8'd70, 12'd0);
        check("s6_hdr_p_100", 32'(dut.hdr_avail[0]), 100);
        check("s6_no_ovf", 32'(fc_overflow), 0);
        fc_update(FC_P, 8'd200, 12'd0);
        check("s6_hdr_sat", 32'(dut.hdr_avail[0]), 255);
        check("s6_ovf_pulse", 32'(fc_overflow), 1);
        @(negedge clk);
        check("s6_ovf_clear", 32'(fc_overflow), 0);
        exp_q.push_back(0);
        set_req(0, FC_P, 12'd0);
        wait_grant(g);
        req = '0;
        @(negedge clk);
        check("s6_busy_mid", 32'(busy), 1);
        arst = 1'b1;
        @(negedge clk);
        check("s6_rst_busy", 32'(busy), 0);
        check("s6_rst_gnt", 32'(gnt), 0);
        check("s6_rst_gnt_idx", 32'(gnt_idx), 0);
        check("s6_rst_hdr_p", 32'(dut.hdr_avail[0]), 32);
        check("s6_rst_data_p", 32'(dut.data_avail[0]), 256);
        arst = 1'b0;
        // Pointer must be back at 0: req0 wins over req1..3.
        exp_q.push_back(0);
        for (int i = 0; i < 4; i++) set_req(i, FC_CPL, 12'd0);
        wait_grant(g);
        req = '0;
        end_xfer();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
